// File: rtl/neuron_preact_mac_if.sv
// Handshake bundle for neuron_preact_mac: the term input port (x, w) and the
// sign-magnitude result port that feeds softplus_8slice.
interface neuron_preact_mac_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x_in;
    logic [31:0] w_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y_out;
    logic        sat;

    modport master (
        output in_valid, x_in, w_in, out_ready,
        input  in_ready, out_valid, y_out, sat
    );

    modport slave (
        input  in_valid, x_in, w_in, out_ready,
        output in_ready, out_valid, y_out, sat
    );
endinterface

// File: rtl/neuron_preact_mac.sv
// Sequential MAC forming a neuron pre-activation in 32-bit sign-magnitude Q.FRAC_BITS.
// Optional bias addition is built only when NEURON_PREACT_BIAS_EN is defined.
module neuron_preact_mac #(
    parameter int N_INPUTS  = 8,
    parameter int FRAC_BITS = 27,
    parameter int ACC_W     = 48
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [31:0]             bias_in,
    output logic                    busy,
    neuron_preact_mac_if.slave      bus
);
    localparam int CNT_W = $clog2(N_INPUTS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_INPUTS - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCUM  = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;
    localparam logic [1:0] OUTPUT = 2'd3;

    function automatic logic [ACC_W-1:0] sm_to_tc(input logic neg, input logic [ACC_W-1:0] mag);
        return neg ? ({ACC_W{1'b0}} - mag) : mag;
    endfunction

    logic [1:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      y_q, y_d;
    logic             sat_q, sat_d;
    logic             in_ready_q, out_valid_q, busy_q;

    logic [61:0]      prod_full_s;
    logic [ACC_W-1:0] term_s;
    logic [ACC_W-1:0] res_s;
    logic [ACC_W-1:0] res_abs_s;
    logic             res_neg_s;
    logic             ovf_s;
    logic [31:0]      y_fin_s;

    // Truncating the magnitude before applying the sign rounds toward zero.
    assign prod_full_s = 62'(bus.x_in[30:0]) * 62'(bus.w_in[30:0]);
    assign term_s      = sm_to_tc(bus.x_in[31] ^ bus.w_in[31], ACC_W'(prod_full_s >> FRAC_BITS));

`ifdef NEURON_PREACT_BIAS_EN
    assign res_s = acc_q + sm_to_tc(bias_in[31], ACC_W'(bias_in[30:0]));
`else
    logic unused_bias_s;
    assign unused_bias_s = ^bias_in;
    assign res_s         = acc_q;
`endif

    assign res_neg_s = res_s[ACC_W-1];
    assign res_abs_s = sm_to_tc(res_neg_s, res_s);
    assign ovf_s     = |res_abs_s[ACC_W-1:31];
    assign y_fin_s   = ovf_s ? {res_neg_s, 31'h7FFFFFFF}
                             : {res_neg_s & (|res_abs_s[30:0]), res_abs_s[30:0]};

    // Next-state and datapath update for the IDLE/ACCUM/FINISH/OUTPUT sequence.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        y_d     = y_q;
        sat_d   = sat_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = {ACC_W{1'b0}};
                    count_d = {CNT_W{1'b0}};
                    state_d = ACCUM;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCUM: begin
                if (bus.in_valid) begin
                    acc_d   = acc_q + term_s;
                    count_d = count_q + CNT_W'(1'b1);
                    if (count_q == LAST_CNT) begin
                        state_d = FINISH;
                    end else begin
                        state_d = ACCUM;
                    end
                end else begin
                    state_d = ACCUM;
                end
            end
            FINISH: begin
                y_d     = y_fin_s;
                sat_d   = ovf_s;
                state_d = OUTPUT;
            end
            OUTPUT: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = OUTPUT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake flags; rst aborts any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= {ACC_W{1'b0}};
            count_q     <= {CNT_W{1'b0}};
            y_q         <= 32'h0000_0000;
            sat_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            y_q         <= y_d;
            sat_q       <= sat_d;
            in_ready_q  <= (state_d == ACCUM);
            out_valid_q <= (state_d == OUTPUT);
            busy_q      <= (state_d != IDLE);
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.y_out     = y_q;
    assign bus.sat       = sat_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_neuron_preact_mac.sv
// Self-checking bench for neuron_preact_mac: vector table, hand-written corner
// sequences and randomized neurons checked against an arithmetic reference model.
module tb_neuron_preact_mac;
    localparam int N = 8;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] bias_in;
    logic        busy;

    neuron_preact_mac_if bus ();

    neuron_preact_mac #(.N_INPUTS(N), .FRAC_BITS(27), .ACC_W(48)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bias_in (bias_in),
        .busy    (busy),
        .bus     (bus)
    );

    typedef struct {
        logic [31:0] x;
        logic [31:0] w;
        logic [31:0] bias;
        logic [31:0] exp_y;
        logic        exp_sat;
        int          gap;
        int          hold;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] xq[$];
    logic [31:0] wq[$];
    vec_t        tbl[8];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    // Reference: exact dot product with plain integer arithmetic, then saturate.
    task automatic model(input logic [31:0] bias, output logic [31:0] y, output logic s);
        longint sum = 0;
        longint mag;
        longint absv;
        for (int i = 0; i < xq.size(); i++) begin
            mag = (longint'(xq[i][30:0]) * longint'(wq[i][30:0])) / (64'sd1 <<< 27);
            sum += (xq[i][31] ^ wq[i][31]) ? -mag : mag;
        end
`ifdef NEURON_PREACT_BIAS_EN
        sum += bias[31] ? -longint'(bias[30:0]) : longint'(bias[30:0]);
`else
        if (bias == 32'h0000_0000) sum += 0;
`endif
        absv = (sum < 0) ? -sum : sum;
        if (absv > 64'sh7FFF_FFFF) begin
            s = 1'b1;
            y = {sum < 0, 31'h7FFFFFFF};
        end else begin
            s = 1'b0;
            y = {(sum < 0), absv[30:0]};
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
        chk("rst_in_ready",  {31'h0, bus.in_ready},  32'h0);
        chk("rst_busy",      {31'h0, busy},          32'h0);
        chk("rst_y_out",     bus.y_out,              32'h0);
        chk("rst_sat",       {31'h0, bus.sat},       32'h0);
    endtask

    task automatic start_pulse();
        @(negedge clk);
        start = 1'b1;
    endtask

    // Present n_terms of xq/wq with random gaps; only in_ready-qualified cycles count.
    task automatic feed(input int n_terms, input int gap_max, input bit noise);
        int  i = 0;
        int  guard = 0;
        bit  go;
        while (i < n_terms && guard < 4000) begin
            @(negedge clk);
            guard++;
            start = noise ? 1'($urandom_range(1, 0)) : 1'b0;
            go = bus.in_ready && ($urandom_range(gap_max, 0) == 0);
            bus.in_valid = go;
            bus.x_in = go ? xq[i] : 32'($urandom);
            bus.w_in = go ? wq[i] : 32'($urandom);
            @(posedge clk);
            if (go) i++;
        end
        if (guard >= 4000) chk("feed_timeout", 32'h0, 32'h1);
    endtask

    task automatic run(input string nm, input int gap_max, input int hold, input bit noise,
                       input logic [31:0] exp_y, input logic exp_sat);
        start_pulse();
        feed(xq.size(), gap_max, noise);
        @(negedge clk);
        bus.in_valid = 1'b0;
        start = 1'b0;
        chk({nm, "_finish_valid"}, {31'h0, bus.out_valid}, 32'h0);
        chk({nm, "_finish_ready"}, {31'h0, bus.in_ready},  32'h0);
        @(negedge clk);
        chk({nm, "_latency_valid"}, {31'h0, bus.out_valid}, 32'h1);
        for (int h = 0; h < hold; h++) begin
            chk({nm, "_hold_y"},     bus.y_out,              exp_y);
            chk({nm, "_hold_sat"},   {31'h0, bus.sat},       {31'h0, exp_sat});
            chk({nm, "_hold_valid"}, {31'h0, bus.out_valid}, 32'h1);
            chk({nm, "_hold_ready"}, {31'h0, bus.in_ready},  32'h0);
            start = noise ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        chk({nm, "_y"},   bus.y_out,        exp_y);
        chk({nm, "_sat"}, {31'h0, bus.sat}, {31'h0, exp_sat});
        bus.out_ready = 1'b1;
        start = noise ? 1'b1 : 1'b0;
        @(negedge clk);
        bus.out_ready = 1'b0;
        start = 1'b0;
        chk({nm, "_single_xfer"}, {31'h0, bus.out_valid}, 32'h0);
        chk({nm, "_idle_busy"},   {31'h0, busy},          32'h0);
        @(negedge clk);
        chk({nm, "_start_ignored"}, {31'h0, busy},         32'h0);
        chk({nm, "_idle_ready"},    {31'h0, bus.in_ready}, 32'h0);
    endtask

    task automatic fill_const(input logic [31:0] x, input logic [31:0] w);
        xq.delete();
        wq.delete();
        for (int i = 0; i < N; i++) begin
            xq.push_back(x);
            wq.push_back(w);
        end
    endtask

    initial begin
        logic [31:0] ey;
        logic        es;
        logic [31:0] mask;

        rst = 1'b1; start = 1'b0; bias_in = 32'h0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.x_in = 32'h0; bus.w_in = 32'h0;

        tbl[0] = '{32'h0800_0000, 32'h0400_0000, 32'h8400_0000,
`ifdef NEURON_PREACT_BIAS_EN
                   32'h1C00_0000,
`else
                   32'h2000_0000,
`endif
                   1'b0, 0, 1};
        tbl[1] = '{32'h8800_0000, 32'h1000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 0, 2};
        tbl[2] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b0, 2, 0};
        tbl[3] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1, 1};
        tbl[4] = '{32'h0800_0000, 32'h8800_0000, 32'h0000_0000, 32'hC000_0000, 1'b0, 3, 2};
        tbl[5] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000, 1'b0, 0, 0};
        tbl[6] = '{32'h8C00_0000, 32'h0000_0003, 32'h0000_0000, 32'h8000_0020, 1'b0, 1, 1};
        tbl[7] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1, 0, 3};

        do_reset();

        for (int t = 0; t < 8; t++) begin
            fill_const(tbl[t].x, tbl[t].w);
            bias_in = tbl[t].bias;
            run($sformatf("vec%0d", t), tbl[t].gap, tbl[t].hold, 1'b0, tbl[t].exp_y, tbl[t].exp_sat);
        end
        bias_in = 32'h0;

        // Alternating +1.0/-1.0 terms cancel to +0, with gaps and a long hold.
        xq.delete();
        wq.delete();
        for (int i = 0; i < N; i++) begin
            xq.push_back((i % 2 == 0) ? 32'h0800_0000 : 32'h8800_0000);
            wq.push_back(32'h0800_0000);
        end
        run("alt_zero", 3, 5, 1'b0, 32'h0000_0000, 1'b0);

        // Abort after 4 of 8 accepts, then a clean run must show no residue.
        fill_const(32'h0800_0000, 32'h0400_0000);
        start_pulse();
        feed(4, 1, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_valid", {31'h0, bus.out_valid}, 32'h0);
        chk("abort_busy",  {31'h0, busy},          32'h0);
        chk("abort_ready", {31'h0, bus.in_ready},  32'h0);
        run("after_abort", 0, 1, 1'b0, 32'h2000_0000, 1'b0);

        // Reset while out_valid is held drops the result.
        fill_const(32'h0800_0000, 32'h0800_0000);
        start_pulse();
        feed(N, 0, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("pre_abort_valid", {31'h0, bus.out_valid}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_out_valid", {31'h0, bus.out_valid}, 32'h0);
        chk("abort_out_y",     bus.y_out,              32'h0);

        // start noise during ACCUM/OUTPUT must be ignored.
        fill_const(32'h0800_0000, 32'h0400_0000);
        run("start_noise", 2, 3, 1'b1, 32'h2000_0000, 1'b0);

        for (int r = 0; r < 24; r++) begin
            xq.delete();
            wq.delete();
            case ($urandom_range(3, 0))
                0:       mask = 32'h7FFF_FFFF;
                1:       mask = 32'h0FFF_FFFF;
                2:       mask = 32'h01FF_FFFF;
                default: mask = 32'h000F_FFFF;
            endcase
            for (int i = 0; i < N; i++) begin
                xq.push_back({1'($urandom_range(1, 0)), 31'($urandom & mask)});
                wq.push_back(($urandom_range(7, 0) == 0) ? 32'h8000_0000
                                                         : {1'($urandom_range(1, 0)), 31'($urandom & mask)});
            end
            bias_in = {1'($urandom_range(1, 0)), 31'($urandom & mask)};
            model(bias_in, ey, es);
            run($sformatf("rand%0d", r), $urandom_range(3, 0), $urandom_range(3, 0),
                1'($urandom_range(1, 0)), ey, es);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
